// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
// Package     : mips_defs
// Description : Shared constants and the store-buffer entry layout used by
//               the MEM-stage store buffer and its forwarding selector.
// Revision    : 1.0 - initial store buffer support
// ============================================================================
package mips_defs;

  // Default number of store-buffer entries (power of two, >= 2)
  localparam int SB_DEPTH = 4;

  // Byte-address width of the data side
  localparam int SB_AW = 32;

  // Byte lanes per data word
  localparam int SB_BE_W = 4;

  // One buffered store: word-granular address, lane-aligned data,
  // per-lane byte enables and the PC of the (latest) store for logging.
  typedef struct packed {
    logic [SB_AW-3:0]   word_addr;
    logic [31:0]        data;
    logic [SB_BE_W-1:0] be;
    logic [31:0]        pc;
  } sb_entry_t;

endpackage : mips_defs
`default_nettype wire

// File: rtl/sb_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module      : sb_fwd_sel
// Description : Per-lane youngest-match selection over the store-buffer
//               entries. Entries are walked oldest to youngest (starting at
//               head, for count entries), so a later match overrides an
//               earlier one and the youngest store supplies each byte.
// Revision    : 1.0 - initial release
// ============================================================================
module sb_fwd_sel
  import mips_defs::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t                   entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]    head,
  input  logic [$clog2(DEPTH):0]      count,
  input  logic [SB_AW-3:0]            ld_word_addr,
  output logic [31:0]                 fwd_data,
  output logic [SB_BE_W-1:0]          fwd_mask
);

  localparam int c_PTR_W = $clog2(DEPTH);

  // Only address/data/be take part in forwarding; the PC travels with the
  // entry for the drain side.
  logic w_pc_unused;

  // Fold the PC fields so they are visibly consumed
  always_comb begin
    w_pc_unused = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      w_pc_unused = w_pc_unused ^ (^entries[k].pc);
    end
  end

  for (genvar gi = 0; gi < SB_BE_W; gi++) begin : g_lane
    logic               w_hit;
    logic [7:0]         w_byte;
    logic [c_PTR_W-1:0] w_idx;

    // Walk valid entries by age; the last match seen is the youngest
    always_comb begin
      w_hit  = 1'b0;
      w_byte = 8'h00;
      w_idx  = head;
      for (int k = 0; k < DEPTH; k++) begin
        w_idx = head + c_PTR_W'(k);
        if ((c_PTR_W+1)'(k) < count) begin
          if ((entries[w_idx].word_addr == ld_word_addr) && entries[w_idx].be[gi]) begin
            w_hit  = 1'b1;
            w_byte = entries[w_idx].data[8*gi +: 8];
          end
        end
      end
    end

    assign fwd_mask[gi]         = w_hit;
    assign fwd_data[8*gi +: 8]  = w_byte;
  end

endmodule : sb_fwd_sel
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Circular store buffer between the MEM-stage pipeline register
//               and the data memory. Coalesces same-word stores into the
//               youngest entry, drains one entry per cycle and forwards
//               pending bytes to MEM-stage loads.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer
  import mips_defs::*;
#(
  parameter int DEPTH = SB_DEPTH,
  // The entry layout comes from the package, so AW must equal SB_AW.
  parameter int AW    = SB_AW
) (
  input  logic                clk,
  input  logic                reset,
  // MEM-stage store port
  input  logic                st_valid,
  input  logic [AW-1:0]       st_addr,
  input  logic [31:0]         st_data,
  input  logic [SB_BE_W-1:0]  st_be,
  input  logic [31:0]         st_pc,
  output logic                st_stall,
  // MEM-stage load forwarding
  input  logic [AW-1:0]       ld_addr,
  output logic [31:0]         ld_fwd_data,
  output logic [SB_BE_W-1:0]  ld_fwd_mask,
  // Data-memory drain port
  output logic                dm_we,
  output logic [AW-1:0]       dm_addr,
  output logic [31:0]         dm_wd,
  output logic [SB_BE_W-1:0]  dm_be,
  output logic [31:0]         dm_pc,
  input  logic                dm_ready,
  output logic                empty
);

  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W:0]   c_CNT_MAX = (c_PTR_W+1)'(DEPTH);

  // Pointer / occupancy state
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_PTR_W:0]   r_count;

  // Entry storage (contents are don't-care while not counted as valid)
  sb_entry_t          r_entries [DEPTH];

  logic [SB_AW-3:0]   w_st_waddr;
  logic [SB_AW-3:0]   w_ld_waddr;
  logic [c_PTR_W-1:0] w_young;
  sb_entry_t          w_young_entry;
  sb_entry_t          w_head_entry;
  sb_entry_t          w_new_entry;
  logic [31:0]        w_coal_data;
  logic               w_full;
  logic               w_nonempty;
  logic               w_deq;
  logic               w_st_acc;
  logic               w_coal;
  logic               w_enq;
  logic               w_unused;

  // Byte-offset bits are irrelevant: lanes are selected by byte enables
  assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};

  assign w_st_waddr    = st_addr[AW-1:2];
  assign w_ld_waddr    = ld_addr[AW-1:2];
  assign w_young       = r_tail - c_PTR_ONE;
  assign w_young_entry = r_entries[w_young];
  assign w_head_entry  = r_entries[r_head];

  assign w_full     = (r_count == c_CNT_MAX);
  assign w_nonempty = (r_count != '0);
  assign w_deq      = w_nonempty && dm_ready;
  assign w_st_acc   = st_valid && !w_full;

  // Merge into the youngest entry unless it is the sole entry leaving now
  assign w_coal = w_st_acc && w_nonempty &&
                  (w_young_entry.word_addr == w_st_waddr) &&
                  !((r_count == c_CNT_ONE) && w_deq);
  assign w_enq  = w_st_acc && !w_coal;

  // Lane-wise merge of the incoming store over the youngest entry's data
  for (genvar gi = 0; gi < SB_BE_W; gi++) begin : g_coal_lane
    assign w_coal_data[8*gi +: 8] = st_be[gi] ? st_data[8*gi +: 8]
                                              : w_young_entry.data[8*gi +: 8];
  end

  // Assemble a fresh entry from the incoming store
  always_comb begin
    w_new_entry           = '0;
    w_new_entry.word_addr = w_st_waddr;
    w_new_entry.data      = st_data;
    w_new_entry.be        = st_be;
    w_new_entry.pc        = st_pc;
  end

  // Advance head/tail and track occupancy; reset discards everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + c_PTR_ONE;
      end
      if (w_deq) begin
        r_head <= r_head + c_PTR_ONE;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write a new entry at the tail, or merge into the youngest entry
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_entries[r_tail] <= w_new_entry;
    end else if (w_coal) begin
      r_entries[w_young].data <= w_coal_data;
      r_entries[w_young].be   <= w_young_entry.be | st_be;
      r_entries[w_young].pc   <= st_pc;
    end
  end

  // Drain port presents the head entry whenever anything is held
  assign dm_we    = w_nonempty;
  assign dm_addr  = {w_head_entry.word_addr, 2'b00};
  assign dm_wd    = w_head_entry.data;
  assign dm_be    = w_head_entry.be;
  assign dm_pc    = w_head_entry.pc;
  assign st_stall = w_full;
  assign empty    = !w_nonempty;

  sb_fwd_sel #(
    .DEPTH (DEPTH)
  ) u_fwd_sel (
    .entries      (r_entries),
    .head         (r_head),
    .count        (r_count),
    .ld_word_addr (w_ld_waddr),
    .fwd_data     (ld_fwd_data),
    .fwd_mask     (ld_fwd_mask)
  );

endmodule : store_buffer
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer. A queue of pending
//               stores is the reference; the driver merges/pushes accepted
//               stores, a monitor compares outputs and pops drained entries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
  import mips_defs::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic [31:0] st_pc;
  logic        st_stall;
  logic [31:0] ld_addr;
  logic [31:0] ld_fwd_data;
  logic [3:0]  ld_fwd_mask;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        dm_ready;
  logic        empty;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_be(st_be), .st_pc(st_pc), .st_stall(st_stall),
    .ld_addr(ld_addr), .ld_fwd_data(ld_fwd_data), .ld_fwd_mask(ld_fwd_mask),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_be(dm_be),
    .dm_pc(dm_pc), .dm_ready(dm_ready), .empty(empty)
  );

  typedef struct {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] pc;
  } mentry_t;

  mentry_t q[$];          // pending stores, oldest first
  int      checks  = 0;
  int      errors  = 0;
  bit      drained = 1'b0; // monitor saw a drain in the current cycle

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a store merges into the youngest pending store of the same word
  function automatic void model_store(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] be, input logic [31:0] pc);
    mentry_t e;
    int n;
    n = q.size();
    if (n > 0 && q[n-1].wa == a[31:2]) begin
      e = q[n-1];
      for (int i = 0; i < 4; i++) if (be[i]) e.d[8*i +: 8] = d[8*i +: 8];
      e.be = e.be | be;
      e.pc = pc;
      q[n-1] = e;
    end else begin
      e.wa = a[31:2];
      e.d  = d;
      e.be = be;
      e.pc = pc;
      q.push_back(e);
    end
  endfunction

  // Monitor: compare outputs against the pending-store queue mid-cycle
  initial begin
    logic [31:0] fd;
    logic [3:0]  fm;
    forever begin
      @(negedge clk);
      if (!reset) begin
        fd = '0;
        fm = '0;
        foreach (q[k]) begin
          if (q[k].wa == ld_addr[31:2]) begin
            for (int i = 0; i < 4; i++) begin
              if (q[k].be[i]) begin
                fd[8*i +: 8] = q[k].d[8*i +: 8];
                fm[i] = 1'b1;
              end
            end
          end
        end
        chk("fwd_mask", ld_fwd_mask, fm);
        chk("fwd_data", ld_fwd_data, fd);
        chk("empty", empty, q.size() == 0);
        chk("dm_we", dm_we, q.size() != 0);
        chk("st_stall", st_stall, q.size() == DEPTH);
        drained = 1'b0;
        if (q.size() != 0) begin
          chk("dm_addr", dm_addr, {q[0].wa, 2'b00});
          chk("dm_wd", dm_wd, q[0].d);
          chk("dm_be", dm_be, q[0].be);
          chk("dm_pc", dm_pc, q[0].pc);
          if (dm_ready) begin
            void'(q.pop_front());
            drained = 1'b1;
          end
        end
      end
    end
  end

  // One cycle of stimulus; called #1 after a rising edge, returns #1 after the next
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic [31:0] pc,
                     input logic rdy, input logic [31:0] la);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    st_pc    = pc;
    dm_ready = rdy;
    ld_addr  = la;
    @(posedge clk);
    if (!reset && v && ((q.size() + int'(drained)) != DEPTH)) model_store(a, d, be, pc);
    #1;
  endtask

  task automatic idle(input logic rdy, input logic [31:0] la);
    cyc(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, rdy, la);
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    st_pc = '0; dm_ready = 1'b1; ld_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_we", dm_we, 0);
    chk("rst_stall", st_stall, 0);
    chk("rst_mask", ld_fwd_mask, 0);
    chk("rst_fdata", ld_fwd_data, 0);
    chk("rst_empty", empty, 1);
    reset = 1'b0;

    // Single store: visible on the drain port one cycle after capture
    cyc(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h1000, 1'b1, 32'h0);
    chk("t1_dm_we", dm_we, 1);
    chk("t1_dm_addr", dm_addr, 32'h10);
    chk("t1_dm_wd", dm_wd, 32'hDEADBEEF);
    idle(1'b1, 32'h0);
    chk("t1_dm_we_off", dm_we, 0);
    chk("t1_empty", empty, 1);

    // Fill and stall
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h100 + 32'(16*i), $urandom, 4'hF, 32'h2000 + 32'(4*i), 1'b0, 32'h0);
    chk("t2_stall_full", st_stall, 1);
    cyc(1'b1, 32'h200, 32'hCAFEF00D, 4'hF, 32'h2010, 1'b0, 32'h0);
    chk("t2_stall_held", st_stall, 1);
    cyc(1'b1, 32'h200, 32'hCAFEF00D, 4'hF, 32'h2010, 1'b1, 32'h0);
    chk("t2_stall_drop", st_stall, 0);
    cyc(1'b1, 32'h200, 32'hCAFEF00D, 4'hF, 32'h2010, 1'b1, 32'h200);
    repeat (6) idle(1'b1, 32'h0);
    chk("t2_empty", empty, 1);

    // Coalesce two partial stores to one word
    cyc(1'b1, 32'h20, 32'h000000AA, 4'h1, 32'h3000, 1'b0, 32'h0);
    cyc(1'b1, 32'h20, 32'h00CC0000, 4'h4, 32'h3004, 1'b0, 32'h20);
    chk("t3_be", dm_be, 4'h5);
    chk("t3_wd", dm_wd, 32'h00CC00AA);
    idle(1'b1, 32'h0);
    chk("t3_one_entry", empty, 1);

    // Forwarding with the youngest store winning each lane
    cyc(1'b1, 32'h30, 32'h11223344, 4'hC, 32'h4000, 1'b0, 32'h30);
    cyc(1'b1, 32'h30, 32'h55667788, 4'h6, 32'h4004, 1'b0, 32'h30);
    chk("t4_mask", ld_fwd_mask, 4'hE);
    chk("t4_data", ld_fwd_data, 32'h11667700);
    idle(1'b1, 32'h0);

    // Reset between edges with entries pending
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h40 + 32'(16*i), $urandom, 4'hF, 32'h5000, 1'b0, 32'h40);
    chk("t5_pre_mask", ld_fwd_mask, 4'hF);
    reset = 1'b1;
    #1;
    chk("t5_dm_we", dm_we, 0);
    chk("t5_mask", ld_fwd_mask, 0);
    chk("t5_empty", empty, 1);
    chk("t5_stall", st_stall, 0);
    q.delete();
    drained = 1'b0;
    #1;
    reset = 1'b0;
    repeat (3) idle(1'b1, 32'h40);
    chk("t5_no_write", dm_we, 0);

    // Back-to-back distinct stores with continuous drain, across wrap
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 32'h400 + 32'(4*i), $urandom, 4'hF, 32'h6000 + 32'(4*i), 1'b1, 32'h0);
    idle(1'b1, 32'h0);
    chk("t6_empty", empty, 1);

    // Randomized traffic over a small word pool
    for (int n = 0; n < 1500; n++)
      cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
          32'h800 + 32'(4*$urandom_range(0, 5)), $urandom,
          4'($urandom_range(1, 15)), $urandom,
          ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0,
          32'h800 + 32'(4*$urandom_range(0, 5)) + 32'($urandom_range(0, 3)));
    repeat (8) idle(1'b1, 32'h0);
    chk("final_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_store_buffer
`default_nettype wire
